// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two requester ports, the cache request/response port and
// the status outputs of cache_port_arbiter.
//
// Handshake semantics:
//   - rN_req is a level. Once raised, rN_rw/addr/wdata stay stable until
//     rN_ack. The requester drops or renews rN_req at the edge that ends the
//     ack cycle.
//   - rN_ack is a one-cycle pulse. rN_rdata/hit/err are meaningful only
//     while rN_ack = 1.
//   - cache_valid_req is a one-cycle strobe. cache_rw/addr/wdata are held
//     from that strobe until the cache answers.
//   - cache_ready is a one-cycle pulse that qualifies cache_hit, cache_miss
//     and cache_rdata. A pulse that arrives while no access is pending is
//     ignored.
interface cache_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          r0_req;
  logic          r0_rw;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;
  logic          r0_hit;
  logic          r0_err;

  logic          r1_req;
  logic          r1_rw;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;
  logic          r1_hit;
  logic          r1_err;

  logic          cache_valid_req;
  logic          cache_rw;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_ready;
  logic          cache_hit;
  logic          cache_miss;
  logic [DW-1:0] cache_rdata;

  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_rw, r0_addr, r0_wdata,
    output r0_ack, r0_rdata, r0_hit, r0_err,
    input  r1_req, r1_rw, r1_addr, r1_wdata,
    output r1_ack, r1_rdata, r1_hit, r1_err,
    output cache_valid_req, cache_rw, cache_addr, cache_wdata,
    input  cache_ready, cache_hit, cache_miss, cache_rdata,
    output hit_count, miss_count, busy
  );

  // Requesters and cache side.
  modport master (
    output r0_req, r0_rw, r0_addr, r0_wdata,
    input  r0_ack, r0_rdata, r0_hit, r0_err,
    output r1_req, r1_rw, r1_addr, r1_wdata,
    input  r1_ack, r1_rdata, r1_hit, r1_err,
    input  cache_valid_req, cache_rw, cache_addr, cache_wdata,
    output cache_ready, cache_hit, cache_miss, cache_rdata,
    input  hit_count, miss_count, busy
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter in front of a direct-mapped cache.
// Only one access is in flight at a time. Each access has a watchdog, so a
// cache that never answers still produces an ack (with err set). Hit and
// miss counts saturate at all-ones.
module cache_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // wd_q counts up to TIMEOUT-1, which needs clog2(TIMEOUT) bits.
  localparam int             WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          win_q;      // 0 = r0 granted, 1 = r1 granted
  logic          rr_q;       // 1 = r1 has priority on a tie
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          hit_q;
  logic          err_q;
  logic [WDW-1:0] wd_q;
  logic [CW-1:0] hit_cnt_q;
  logic [CW-1:0] miss_cnt_q;

  logic grant1;
  logic wd_expired;

  // r1 wins when it is the only requester, or on a tie when r0 was served last.
  assign grant1     = bus.r1_req & (~bus.r0_req | rr_q);
  assign wd_expired = (wd_q == WD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d             = state_q;
    bus.cache_valid_req = 1'b0;
    bus.r0_ack          = 1'b0;
    bus.r1_ack          = 1'b0;
    bus.busy            = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (bus.r0_req || bus.r1_req) state_d = ISSUE;
      ISSUE: begin
        bus.cache_valid_req = 1'b1;
        state_d             = WAIT;
      end
      WAIT:  if (bus.cache_ready || wd_expired) state_d = RESP;
      RESP: begin
        bus.r0_ack = ~win_q;
        bus.r1_ack = win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, request latch, watchdog, response capture and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= 1'b0;
      rr_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.r0_req || bus.r1_req) begin
            win_q   <= grant1;
            rw_q    <= grant1 ? bus.r1_rw    : bus.r0_rw;
            addr_q  <= grant1 ? bus.r1_addr  : bus.r0_addr;
            wdata_q <= grant1 ? bus.r1_wdata : bus.r0_wdata;
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          if (bus.cache_ready) begin
            rdata_q <= bus.cache_rdata;
            hit_q   <= bus.cache_hit;
            err_q   <= 1'b0;
          end else if (wd_expired) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: rr_q <= ~win_q;
        default: ;
      endcase
    end
  end

  // Saturating hit/miss counters; only a ready that completes a pending access counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == WAIT && bus.cache_ready) begin
      if (bus.cache_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else if (bus.cache_miss) begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  // Cache request fields are held from the latch for the whole access.
  assign bus.cache_rw    = rw_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;

  // Response fields are shown only on the winner's port during its ack.
  assign bus.r0_rdata = bus.r0_ack ? rdata_q : '0;
  assign bus.r0_hit   = bus.r0_ack & hit_q;
  assign bus.r0_err   = bus.r0_ack & err_q;
  assign bus.r1_rdata = bus.r1_ack ? rdata_q : '0;
  assign bus.r1_hit   = bus.r1_ack & hit_q;
  assign bus.r1_err   = bus.r1_ack & err_q;

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  assign dbg_state_o    = state_q;

endmodule
